// File: rtl/vec_mul_sequencer.sv
// Job sequencer for the vector-multiply datapath: optional weight load, then an
// address stream into the unified buffer and a delayed result-write stream.
//
// state   | meaning
// IDLE    | waiting for start; outputs quiet
// WLOAD   | pop one weight set from the FIFO
// WRELOAD | latch the popped weights into the array
// RUN     | address stream and PIPE_LATENCY-delayed result stream
// FIN     | one-cycle done pulse
module vec_mul_sequencer #(
  parameter int ADDRESSSIZE  = 10,
  parameter int MATRIX_SIZE  = 64,
  parameter int PIPE_LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] base_addr,
  input  logic [6:0]             num_vectors,
  input  logic                   reload_weights,
  output logic                   busy,
  output logic                   done,
  output logic                   fifo_read_enable,
  output logic                   weight_reload,
  output logic [ADDRESSSIZE-1:0] sram_address,
  output logic                   addr_valid,
  output logic                   valid_address,
  output logic [5:0]             result_address
);

  localparam int CW = $clog2(PIPE_LATENCY + MATRIX_SIZE + 1);

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    WRELOAD,
    RUN,
    FIN
  } state_t;

  state_t                 state;
  logic [CW-1:0]          c_q;
  logic [6:0]             n_q;
  logic [ADDRESSSIZE-1:0] base_q;
  logic                   reload_q;

  logic [6:0]             n_in;
  logic [CW-1:0]          lat_c;
  logic [CW-1:0]          n_c;
  logic [CW-1:0]          last_c;
  logic                   in_addr;
  logic                   in_res;
  logic [ADDRESSSIZE-1:0] addr_off;

  assign n_in     = (num_vectors > 7'(MATRIX_SIZE)) ? 7'(MATRIX_SIZE) : num_vectors;
  assign lat_c    = CW'(PIPE_LATENCY);
  assign n_c      = CW'(n_q);
  assign last_c   = lat_c + n_c - CW'(1);
  assign in_addr  = (c_q < n_c);
  assign in_res   = (c_q >= lat_c) && (c_q < (lat_c + n_c));
  assign addr_off = ADDRESSSIZE'(c_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      c_q              <= '0;
      n_q              <= '0;
      base_q           <= '0;
      reload_q         <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      fifo_read_enable <= 1'b0;
      weight_reload    <= 1'b0;
      sram_address     <= '0;
      addr_valid       <= 1'b0;
      valid_address    <= 1'b0;
      result_address   <= '0;
    end else begin
      busy             <= 1'b1;
      done             <= 1'b0;
      fifo_read_enable <= 1'b0;
      weight_reload    <= 1'b0;
      sram_address     <= '0;
      addr_valid       <= 1'b0;
      valid_address    <= 1'b0;
      result_address   <= '0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          // busy is still high on the edge that ends the done cycle, so a
          // start coincident with done is dropped here.
          if (start && !busy) begin
            base_q   <= base_addr;
            n_q      <= n_in;
            reload_q <= reload_weights;
            c_q      <= '0;
            if (n_in == 7'd0)
              state <= FIN;
            else if (reload_weights)
              state <= WLOAD;
            else
              state <= RUN;
          end
        end
        WLOAD: begin
          fifo_read_enable <= 1'b1;
          state            <= WRELOAD;
        end
        WRELOAD: begin
          weight_reload <= 1'b1;
          c_q           <= '0;
          state         <= RUN;
        end
        RUN: begin
          addr_valid    <= in_addr;
          sram_address  <= in_addr ? (base_q + addr_off) : '0;
          valid_address <= in_res;
          result_address <= in_res ? 6'(c_q - lat_c) : 6'd0;
          c_q           <= c_q + CW'(1);
          if (c_q == last_c)
            state <= FIN;
        end
        FIN: begin
          done     <= 1'b1;
          c_q      <= '0;
          reload_q <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Directed bench for vec_mul_sequencer: job table checked cycle by cycle,
// plus reset, ignored-start, back-to-back and mid-job reset sequences.
module tb_vec_mul_sequencer;

  localparam int AS = 10;
  localparam int PL = 3;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [AS-1:0] base_addr;
  logic [6:0]    num_vectors;
  logic          reload_weights;
  logic          busy;
  logic          done;
  logic          fifo_read_enable;
  logic          weight_reload;
  logic [AS-1:0] sram_address;
  logic          addr_valid;
  logic          valid_address;
  logic [5:0]    result_address;

  vec_mul_sequencer #(.ADDRESSSIZE(AS), .MATRIX_SIZE(64), .PIPE_LATENCY(PL)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .start            (start),
    .base_addr        (base_addr),
    .num_vectors      (num_vectors),
    .reload_weights   (reload_weights),
    .busy             (busy),
    .done             (done),
    .fifo_read_enable (fifo_read_enable),
    .weight_reload    (weight_reload),
    .sram_address     (sram_address),
    .addr_valid       (addr_valid),
    .valid_address    (valid_address),
    .result_address   (result_address)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // s: first RUN cycle, n: clamped length, d: done cycle (all hand-computed)
  typedef struct {
    logic [AS-1:0] base;
    logic [6:0]    nv;
    logic          rl;
    int            s;
    int            n;
    int            d;
  } vec_t;

  vec_t tbl [6];
  int   total;
  int   passed;

  function automatic logic [21:0] act_pack();
    return {busy, done, fifo_read_enable, weight_reload, addr_valid, sram_address,
            valid_address, result_address};
  endfunction

  function automatic logic [21:0] exp_pack(vec_t v, int k);
    logic          e_busy, e_done, e_fre, e_wr, e_av, e_va;
    logic [AS-1:0] e_sa;
    logic [5:0]    e_ra;
    e_sa = '0;
    e_ra = '0;
    e_fre = 1'b0;
    e_wr  = 1'b0;
    e_av  = 1'b0;
    e_va  = 1'b0;
    e_busy = (k >= 1) && (k <= v.d);
    e_done = (k == v.d);
    if (v.n > 0) begin
      e_fre = v.rl && (k == 1);
      e_wr  = v.rl && (k == 2);
      e_av  = (k >= v.s) && (k < v.s + v.n);
      e_va  = (k >= v.s + PL) && (k < v.s + PL + v.n);
      if (e_av) e_sa = AS'(int'(v.base) + k - v.s);
      if (e_va) e_ra = 6'(k - v.s - PL);
    end
    return {e_busy, e_done, e_fre, e_wr, e_av, e_sa, e_va, e_ra};
  endfunction

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic start_job(input int idx);
    base_addr      = tbl[idx].base;
    num_vectors    = tbl[idx].nv;
    reload_weights = tbl[idx].rl;
    start          = 1'b1;
    @(negedge clk);
  endtask

  // Entered at the cycle-0 sample point; leaves at cycle d+2.
  task automatic check_job(input int idx, input int inj_a, input int inj_b, input bit chain);
    int vcnt;
    int first_addr;
    vcnt = 0;
    first_addr = -1;
    for (int k = 0; k <= tbl[idx].d + 1; k++) begin
      check($sformatf("job%0d_cyc%0d", idx, k), act_pack(), exp_pack(tbl[idx], k));
      if (valid_address) vcnt++;
      if (addr_valid && first_addr < 0) first_addr = int'(sram_address);
      start = (k == inj_a) || (k == inj_b) || (chain && k == tbl[idx].d + 1);
      @(negedge clk);
    end
    check_int($sformatf("job%0d_valid_count", idx), vcnt, tbl[idx].n);
    check_int($sformatf("job%0d_first_addr", idx), first_addr,
              (tbl[idx].n == 0) ? -1 : int'(tbl[idx].base));
  endtask

  initial begin
    total = 0;
    passed = 0;
    tbl[0] = '{base: 10'd10,   nv: 7'd4,   rl: 1'b1, s: 3, n: 4,  d: 10};
    tbl[1] = '{base: 10'd1022, nv: 7'd100, rl: 1'b0, s: 1, n: 64, d: 68};
    tbl[2] = '{base: 10'd5,    nv: 7'd0,   rl: 1'b1, s: 1, n: 0,  d: 1};
    tbl[3] = '{base: 10'd0,    nv: 7'd1,   rl: 1'b0, s: 1, n: 1,  d: 5};
    tbl[4] = '{base: 10'd100,  nv: 7'd64,  rl: 1'b1, s: 3, n: 64, d: 70};
    tbl[5] = '{base: 10'd1023, nv: 7'd3,   rl: 1'b0, s: 1, n: 3,  d: 7};

    rstn = 1'b0;
    start = 1'b0;
    base_addr = '0;
    num_vectors = '0;
    reload_weights = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start          = 1'($urandom);
      base_addr      = AS'($urandom);
      num_vectors    = 7'($urandom);
      reload_weights = 1'($urandom);
      check($sformatf("in_reset_%0d", i), act_pack(), 22'd0);
    end
    @(negedge clk);
    start = 1'b0;
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("idle_%0d", i), act_pack(), 22'd0);
    end

    for (int j = 0; j < 6; j++) begin
      start_job(j);
      check_job(j, -1, -1, 1'b0);
      @(negedge clk);
    end

    // starts at cycle 4 and on the done cycle are dropped; start at cycle 11 runs
    start_job(0);
    check_job(0, 4, 10, 1'b1);
    start = 1'b0;
    check_job(0, -1, -1, 1'b0);
    @(negedge clk);

    start_job(0);
    for (int k = 0; k <= 5; k++) begin
      check($sformatf("pre_abort_cyc%0d", k), act_pack(), exp_pack(tbl[0], k));
      start = 1'b0;
      if (k < 5) @(negedge clk);
    end
    rstn = 1'b0;
    #1;
    check("abort_immediate", act_pack(), 22'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort_hold_%0d", i), act_pack(), 22'd0);
    end
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("after_abort_%0d", i), act_pack(), 22'd0);
    end
    start_job(0);
    check_job(0, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vec_mul_sequencer.md
# vec_mul_sequencer

Job sequencer for the 64-wide vector-multiply datapath. On a start pulse it optionally pops one weight set from the weight FIFO and latches it into the array. It then streams a contiguous run of input-vector addresses to the unified buffer. After a fixed pipeline latency it drives the result-write strobe and result address for every vector. It replaces the free-running start/counter control in the top level and gives the host a clean busy/done handshake.

## Interface
Parameters:
- ADDRESSSIZE, 10, width of the unified-buffer address.
- MATRIX_SIZE, 64, maximum vectors per job; also the size of the result address space.
- PIPE_LATENCY, 3, cycles from an address issue to the matching result being writable; legal range 1..255.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job request; sampled only in IDLE.
- base_addr  in  ADDRESSSIZE  first input-vector address; captured on accepted start.
- num_vectors  in  7  vectors in the job; captured on accepted start.
- reload_weights  in  1  captured on accepted start; 1 = run the weight-load phase first.
- busy  out  1  high while a job is in progress.
- done  out  1  one-cycle pulse at job completion.
- fifo_read_enable  out  1  weight FIFO pop strobe.
- weight_reload  out  1  array weight-latch strobe.
- sram_address  out  ADDRESSSIZE  unified-buffer read address.
- addr_valid  out  1  sram_address carries a job address this cycle.
- valid_address  out  1  result-write strobe.
- result_address  out  6  result SRAM row for the current valid_address.

## Operation
- States: IDLE, WLOAD, WRELOAD, RUN, FIN. All outputs are registered.
- Reset value of every output is 0. Reset puts the FSM in IDLE and clears all counters and captured fields.
- Start capture in IDLE when start=1:
  - Capture base_addr, reload_weights, and N.
  - N = min(num_vectors, MATRIX_SIZE).
- IDLE transitions after start:
  - N=0: go to FIN; no FIFO pop, no reads, no writes.
  - reload_weights=1: go to WLOAD.
  - Otherwise: go to RUN with the cycle counter c=0.
- WLOAD: fifo_read_enable=1 for exactly one cycle, then WRELOAD.
- WRELOAD: weight_reload=1 for exactly one cycle, then RUN with c=0.
- RUN: c increments every cycle. Address stream and result stream overlap when PIPE_LATENCY < N.
  - Address stream, while c<N: addr_valid=1 and sram_address = (base + c) mod 2^ADDRESSSIZE.
  - Result stream, while PIPE_LATENCY ≤ c < PIPE_LATENCY+N: valid_address=1 and result_address = c − PIPE_LATENCY.
  - Exit: when c = PIPE_LATENCY+N−1, go to FIN.
- FIN: done=1 for one cycle, then IDLE.
- Outside the address stream, sram_address=0 and addr_valid=0. Outside the result stream, result_address=0 and valid_address=0.
- busy=1 in WLOAD, WRELOAD, RUN and FIN; busy=0 in IDLE.
- A start pulse while busy=1 is ignored and never queued. A start pulse in the same cycle as done is also ignored.
- Reset asserted mid-job aborts immediately. No done pulse is produced, and strobes drop to 0 asynchronously.

## Timing
- Accepted start at edge 0. Cycle k means the registered outputs after edge k.
- With reload: fifo_read_enable at cycle 1, weight_reload at cycle 2, RUN begins at cycle S=3.
- Without reload: S=1.
- Address i (0..N−1) appears at cycle S+i.
- Result i (valid_address with result_address=i) appears at cycle S+PIPE_LATENCY+i.
- done at cycle S+PIPE_LATENCY+N.
- busy spans cycles 1..S+PIPE_LATENCY+N inclusive.
- N=0: done and busy both high at cycle 1 only.
- Earliest next accepted start is at the edge that ends the done cycle + 1, i.e. the first cycle with busy=0.

## Test plan
- Reset: hold rstn=0 with random inputs -> all outputs 0. Release, idle 5 cycles -> outputs stay 0.
- Full job: base=10, N=4, reload=1, PIPE_LATENCY=3, start at edge 0. Required response:
  - fifo_read_enable at cycle 1, weight_reload at cycle 2.
  - addresses 10,11,12,13 at cycles 3–6.
  - valid_address at cycles 6–9 with result_address 0–3.
  - done at cycle 10; busy over cycles 1–10.
- Wrap and clamp: base=1022, num_vectors=100, reload=0. Required response:
  - addresses 1022,1023,0,1,…,61 over 64 cycles.
  - exactly 64 valid_address strobes, result_address 0–63.
  - done at cycle 68.
- Zero length: num_vectors=0, reload=1 -> done and busy at cycle 1 only. fifo_read_enable, weight_reload, addr_valid and valid_address never assert.
- Ignored start: pulse start again at cycle 4 of the full-job scenario, and again on the done cycle. Both are ignored and the timeline is unchanged. A start at cycle 11 is accepted.
- Reset mid-job: assert rstn=0 at cycle 5 of the full-job scenario -> all outputs 0 immediately. No done pulse. A new job after release runs the exact full-job timeline.
